// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TIMEOUT = 255;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle counter for the arbiter; flags the TIMEOUT-th consecutive enabled cycle.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts completed busy cycles, so the current cycle is number cnt_q+1
  assign expired = en && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !expired)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one req/ready memory between fetch and data ports and freezes the pipeline until both are served.
// Optional watchdog abort is enabled with the MEM_ARB_TIMEOUT_EN macro.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall,
  output logic              timeout_err
);

  arb_state_e        state_q, state_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;

  logic if_pend, dm_pend, busy, wd_expired, abort;

  // The ack and done terms keep a held request from being served twice in one pipeline cycle
  assign if_pend = if_req & ~if_done_q & ~if_ack_q;
  assign dm_pend = dm_req & ~dm_done_q & ~dm_ack_q;
  assign stall   = if_pend | dm_pend;
  assign busy    = (state_q != IDLE);
  assign abort   = busy & ~mem_ready & wd_expired;

`ifdef MEM_ARB_TIMEOUT_EN
  logic timeout_err_q, timeout_err_d;

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (~busy),
    .en      (busy),
    .expired (wd_expired)
  );

  always_comb begin
    timeout_err_d = timeout_err_q | abort;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_err_q <= 1'b0;
    else     timeout_err_q <= timeout_err_d;
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wd_expired     = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    // Done flags survive only while the pipeline stays frozen
    if_done_d   = stall & (if_done_q | if_ack_q);
    dm_done_d   = stall & (dm_done_q | dm_ack_q);

    case (state_q)
      IDLE: begin
        // Data belongs to the older instruction, so it wins a tie
        if (dm_pend) begin
          state_d     = BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
        end else if (if_pend) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end
      end
      BUSY_IF: begin
        if (mem_ready) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          if_ack_d   = 1'b1;
          if_rdata_d = mem_rdata;
        end else if (abort) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          if_ack_d   = 1'b1;
          if_rdata_d = '0;
        end
      end
      BUSY_DM: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          dm_ack_d  = 1'b1;
          if (!mem_we_q)
            dm_rdata_d = mem_rdata;
        end else if (abort) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          dm_ack_d   = 1'b1;
          dm_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, ack scoreboard and reset/watchdog sequences.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata;
  logic        if_ack, dm_ack;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall, timeout_err;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall(stall), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- memory model ----------------
  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h10) return 32'h8C010004;
    return (a ^ 32'h5A5A0000) + 32'h1234;
  endfunction

  int          lat = 1;        // 0 = never ready
  int          wait_cnt = 0;
  int          hs_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic [31:0] hs_log [64];

  assign mem_ready = mem_req && (lat != 0) && (wait_cnt == lat - 1);
  assign mem_rdata = memval(mem_addr);

  always @(posedge clk or posedge rst) begin
    if (rst)                        wait_cnt <= 0;
    else if (!mem_req || mem_ready) wait_cnt <= 0;
    else                            wait_cnt <= wait_cnt + 1;
  end

  always @(posedge clk) begin
    if (!rst && mem_req && mem_ready) begin
      hs_log[hs_cnt % 64] <= mem_addr;
      hs_cnt <= hs_cnt + 1;
      if (mem_we) begin
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= mem_addr;
        wr_data <= mem_wdata;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  logic [31:0] dm_model = '0;
  int          dm_acks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Sample at the falling edge; acks pop the expected read data
  task automatic sample();
    @(negedge clk);
    if (!rst) begin
      if (if_ack) begin
        if (if_q.size() == 0) chk("if_unexpected_ack", {31'd0, if_ack}, 32'd0);
        else                  chk("if_rdata", if_rdata, if_q.pop_front());
      end
      if (dm_ack) begin
        dm_acks++;
        if (dm_q.size() == 0) chk("dm_unexpected_ack", {31'd0, dm_ack}, 32'd0);
        else                  chk("dm_rdata", dm_rdata, dm_q.pop_front());
      end
    end
  endtask

  task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic dw, input logic [31:0] da, input logic [31:0] dd);
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
  endtask

  typedef struct {
    logic        ifr;
    logic [31:0] ia;
    logic        dmr;
    logic        dmw;
    logic [31:0] da;
    logic [31:0] dw;
    int          lat;
    int          exp_if_c;   // cycle of if_ack relative to request, -1 = none
    int          exp_dm_c;
    int          exp_stall;  // number of stall cycles
  } vec_t;

  vec_t vecs[9];

  // Requests stay high until stall drops, as a frozen pipeline would hold them
  task automatic run_vec(input vec_t v, input int idx);
    int  s0, w0, if_c, dm_c, ns;
    bit  fin;
    s0 = hs_cnt; w0 = wr_cnt; if_c = -1; dm_c = -1; ns = 0; fin = 1'b0;
    lat = v.lat;
    if (v.ifr) if_q.push_back(memval(v.ia));
    if (v.dmr) begin
      if (!v.dmw) dm_model = memval(v.da);
      dm_q.push_back(dm_model);
    end
    set_in(v.ifr, v.ia, v.dmr, v.dmw, v.da, v.dw);
    for (int c = 0; c < 40; c++) begin
      sample();
      if (if_ack) if_c = c;
      if (dm_ack) dm_c = c;
      if (stall)  ns++;
      fin = !stall;
      next();
      if (fin) break;
    end
    set_in(1'b0, '0, 1'b0, 1'b0, '0, '0);
    sample();
    next();
    chk($sformatf("v%0d_finished", idx), {31'd0, fin}, 32'd1);
    chk($sformatf("v%0d_if_ack_cycle", idx), 32'(if_c), 32'(v.exp_if_c));
    chk($sformatf("v%0d_dm_ack_cycle", idx), 32'(dm_c), 32'(v.exp_dm_c));
    chk($sformatf("v%0d_stall_cycles", idx), 32'(ns), 32'(v.exp_stall));
    chk($sformatf("v%0d_mem_txns", idx), 32'(hs_cnt - s0), 32'(int'(v.ifr) + int'(v.dmr)));
    chk($sformatf("v%0d_mem_writes", idx), 32'(wr_cnt - w0), 32'(int'(v.dmr & v.dmw)));
    chk($sformatf("v%0d_first_addr", idx), hs_log[s0 % 64], v.dmr ? v.da : v.ia);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0;
    //            ifr   ia          dmr   dmw   da          dw            lat if_c dm_c stall
    vecs[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   32'h0,        1,  2, -1, 2};
    vecs[1] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h100, 32'h0,        2, -1,  3, 3};
    vecs[2] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0,        3,  8,  4, 8};
    vecs[3] = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h104, 32'h0,        1,  4,  2, 4};
    vecs[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h20,  32'hDEADBEEF, 1, -1,  2, 2};
    vecs[5] = '{1'b1, 32'h48, 1'b0, 1'b0, 32'h0,   32'h0,        4,  5, -1, 5};
    vecs[6] = '{1'b1, 32'h4C, 1'b1, 1'b1, 32'h20,  32'hDEADBEEF, 3,  8,  4, 8};
    vecs[7] = '{1'b1, 32'h50, 1'b1, 1'b1, 32'h24,  32'h12345678, 2,  6,  3, 6};
    vecs[8] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h108, 32'h0,        1, -1,  2, 2};

    // ---- reset with a fetch request held ----
    rst = 1'b1;
    lat = 1;
    set_in(1'b1, 32'h10, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("rst_ctrl", {27'd0, mem_req, mem_we, if_ack, dm_ack, timeout_err}, 32'd0);
      chk("rst_mem_bus", mem_addr | mem_wdata, 32'd0);
      chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
    end
    next();
    rst = 1'b0;
    if_q.push_back(memval(32'h10));
    sample();
    next();
    chk("rel_mem_req", {31'd0, mem_req}, 32'd1);
    chk("rel_mem_addr", mem_addr, 32'h10);
    begin
      bit fin;
      fin = 1'b0;
      for (int c = 0; c < 20; c++) begin
        sample();
        fin = !stall;
        next();
        if (fin) break;
      end
      chk("rel_done", {31'd0, fin}, 32'd1);
    end
    set_in(1'b0, '0, 1'b0, 1'b0, '0, '0);
    sample();
    next();

    // ---- vector table ----
    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], i);
      if (i == 6) begin
        chk("store_addr", wr_addr, 32'h20);
        chk("store_data", wr_data, 32'hDEADBEEF);
      end
    end

    // ---- reset in the second BUSY_DM cycle ----
    lat = 0;
    a0 = dm_acks;
    set_in(1'b0, '0, 1'b1, 1'b0, 32'h100, '0);
    sample();
    next();
    chk("mr_busy_req", {31'd0, mem_req}, 32'd1);
    sample();
    next();
    rst = 1'b1;
    set_in(1'b0, '0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("mr_req_drop", {31'd0, mem_req}, 32'd0);
    dm_model = '0;
    sample();
    next();
    sample();
    next();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      next();
    end
    chk("mr_no_ack", 32'(dm_acks - a0), 32'd0);
    chk("mr_idle_req", {31'd0, mem_req}, 32'd0);
    chk("mr_stall", {31'd0, stall}, 32'd0);
    run_vec(vecs[0], 9);

`ifdef MEM_ARB_TIMEOUT_EN
    // ---- watchdog abort: memory never answers ----
    begin
      int  dm_c;
      bit  fin;
      dm_c = -1; fin = 1'b0;
      lat = 0;
      dm_model = '0;
      dm_q.push_back(32'd0);
      set_in(1'b0, '0, 1'b1, 1'b0, 32'h100, '0);
      for (int c = 0; c < 30; c++) begin
        sample();
        if (dm_ack) dm_c = c;
        fin = !stall;
        next();
        if (fin) break;
      end
      set_in(1'b0, '0, 1'b0, 1'b0, '0, '0);
      chk("wd_finished", {31'd0, fin}, 32'd1);
      chk("wd_ack_cycle", 32'(dm_c), 32'd5);
      chk("wd_err_set", {31'd0, timeout_err}, 32'd1);
      chk("wd_mem_req", {31'd0, mem_req}, 32'd0);
      sample();
      next();
      run_vec(vecs[0], 10);
      chk("wd_err_sticky", {31'd0, timeout_err}, 32'd1);
      rst = 1'b1;
      #1;
      chk("wd_err_clear", {31'd0, timeout_err}, 32'd0);
      next();
      rst = 1'b0;
      next();
    end
`else
    chk("no_wd_err", {31'd0, timeout_err}, 32'd0);
`endif

    chk("sb_drain", 32'(if_q.size() + dm_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
